// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: receive FSM states and 8N1 frame constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned STOP_BITS            = 1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers.
// The head entry is shown combinationally on rd_data.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_write;
    logic             do_read;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // A write into a full FIFO only lands when the head is popped in the same cycle.
    always_comb begin
        do_write = wr_en && (!full || rd_en);
        do_read  = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_write) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: input synchronizer, receive FSM, shift register,
// error pulses and a byte FIFO behind a valid/ready interface.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]  BIT_FINAL = 3'(DATA_BITS - 1);

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_int_n;

    logic                 rxd_meta_q, rxd_meta_d;
    logic                 rxd_s_q, rxd_s_d;
    logic                 rxd_prev_q, rxd_prev_d;   // registered copy of rxd_s for edge detect
    rx_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    logic                 bit_done;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Reset synchronizer: assertion is immediate, release is aligned to clk.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int_n = rst_sync_q[1];

    assign bit_done  = (bit_q == BIT_FINAL);
    assign pop       = rx_ready && !fifo_empty;
    assign rx_valid  = !fifo_empty;
    assign rx_busy   = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Next-state logic for the synchronizer, receive FSM and error pulses.
    // The FIFO is written directly at the stop-sample edge; the error pulses
    // are registered so they appear in the following cycle.
    always_comb begin
        rxd_meta_d  = rxd;
        rxd_s_d     = rxd_meta_q;
        rxd_prev_d  = rxd_s_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rxd_prev_q && !rxd_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    if (!rxd_s_q) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_done) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (rxd_s_q) begin
                        push = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        overrun_d = push && fifo_full && !pop;
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_prev_q  <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd_meta_d;
            rxd_s_q     <= rxd_s_d;
            rxd_prev_q  <= rxd_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_int_n),
        .wr_en  (push),
        .wr_data(shift_q),
        .rd_en  (pop),
        .rd_data(rx_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver that decodes the SOPC's uart_txd serial stream (8N1, LSB first) and presents received bytes on a valid/ready byte interface.
- Fronted by a 2-flop synchronizer and backed by a small byte FIFO.
- Used as the console-capture peer in SOPC system benches and synthesizable for on-board loopback/monitor use.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 16..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, idle high; connect to SOPC uart_txd.
- rx_data  out  8  byte at FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts; pop when rx_valid & rx_ready.
- rx_busy  out  1  frame in progress (state != IDLE).
- frame_err  out  1  1-cycle pulse: stop bit sampled 0.
- overrun  out  1  1-cycle pulse: good byte dropped because FIFO full.

Behaviour:
- Reset (async assert, sync deassert inside block): synchronizer flops=1, state=IDLE, bit counter=0, shift reg=0, FIFO empty, rx_valid=0, rx_data=0, rx_busy=0, frame_err=0, overrun=0. Reset mid-frame aborts the frame; no byte and no error pulse results.
- rxd passes through 2 flops (rxd_s); all decisions use rxd_s, plus a registered copy rxd_d for edge detection.
- States:
  - IDLE: on rxd_d=1 & rxd_s=0 (falling edge) -> START, cnt=0.
  - START: cnt increments each cycle. At cnt=CLKS_PER_BIT/2-1 (integer division), if rxd_s=0 -> DATA with cnt=0, bit=0; if rxd_s=1 -> IDLE (glitch rejected, no pulse).
  - DATA: at cnt=CLKS_PER_BIT-1, shift rxd_s into the MSB of the shift reg (right shift, so LSB-first order is restored), cnt=0, bit++. After bit 7 is sampled -> STOP.
  - STOP: at cnt=CLKS_PER_BIT-1, sample rxd_s, then -> IDLE.
    - If 1: push byte.
    - If 0: frame_err pulses next cycle, byte discarded.
- Re-arm: IDLE needs a fresh falling edge, so a held-low line (break) yields exactly one frame_err per break.
- Push timing: FIFO is written in the cycle after the stop sample; rx_valid rises in that cycle if the FIFO was empty. Latency is 1 cycle from stop sample to rx_valid.
- Full FIFO:
  - A push into a full FIFO with no pop in the same cycle drops the new byte. Stored data is kept and overrun pulses.
  - Push and pop in the same cycle while full: both happen, no overrun.
  - Push and pop while empty cannot occur, since rx_valid=0 when empty.
- Output stability: rx_data and rx_valid hold stable while rx_valid=1 & rx_ready=0. Bytes are delivered in arrival order.
- Pointer wrap-around: pointers are log2(FIFO_DEPTH)+1 bits. Full = MSBs differ and LSBs equal; empty = all bits equal.
- Counters:
  - cnt is 16 bits and wraps only by explicit clear.
  - bit is 3 bits, with a separate done flag on bit 7.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE, START, DATA, STOP);
  - the localparam default CLKS_PER_BIT=434;
  - the frame constants DATA_BITS=8 and STOP_BITS=1.
- Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH) provides:
  - inputs wr_en, wr_data, rd_en;
  - outputs rd_data, full, empty.
  - rd_data shows the head combinationally from the register array.
- Top contains synchronizer, FSM, shift register and error pulses.

Test Plan (CLKS_PER_BIT=434, 20 ns clk, rx_ready=1 unless stated):
1. Drive 0x55 8N1 on rxd -> exactly one rx_valid cycle with rx_data=0x55; frame_err=0, overrun=0; rx_busy high for about 9.5 bit times.
2. Glitch: rxd low for 100 cycles, then high -> FSM returns to IDLE, no rx_valid, no frame_err. Then send 0xA3 -> 0xA3 received.
3. Send 0x3C with stop bit driven 0, then rxd high -> one frame_err pulse, no rx_valid. A following 0x3C with a good stop bit is received correctly.
4. rx_ready=0; send 0x01..0x05 back-to-back:
   - FIFO fills with 0x01..0x04, and one overrun pulses after byte 5's stop sample.
   - Then rx_ready=1 -> 0x01,0x02,0x03,0x04 pop in order and rx_valid falls.
5. FIFO full with rx_ready asserted exactly in the push cycle of a 5th byte 0x05 -> no overrun; subsequent reads give 0x02,0x03,0x04,0x05.
6. Assert rst_n=0 mid-way through data bit 4 of 0xFF, release, then send 0x81 -> only 0x81 appears. No frame_err or overrun at any point, and all outputs are at reset values while rst_n=0.
